// File: rtl/mips_run_ctrl_pkg.sv
// Shared definitions for the MIPS run controller: run-state encoding,
// 32-bit counter saturation and the halt-detection rule constants.
package mips_run_ctrl_pkg;

    // Run sequence: hold the core in reset, run it, let the pipeline drain
    // after a halt, then park until the next external reset.
    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } run_state_e;

    // Flat encodings used for the state register so it can be probed as a
    // plain 2-bit vector.
    localparam logic [1:0] ST_HOLD  = HOLD;
    localparam logic [1:0] ST_RUN   = RUN;
    localparam logic [1:0] ST_DRAIN = DRAIN;
    localparam logic [1:0] ST_DONE  = DONE;

    // Cycle and retire counters stick at this value instead of wrapping.
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    // Repeat count loaded when a retire lands on a PC different from the
    // previous one; a matching PC adds REP_STEP instead.
    localparam int REP_FIRST = 1;
    localparam int REP_STEP  = 1;

    // Saturating increment for the 32-bit run counters.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == CNT_MAX) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pc_history_ring.sv
// Ring buffer of the most recently retired PCs. rd_idx = 0 returns the
// newest entry, rd_idx = k the entry written k retires earlier. Entries
// never written since reset read as zero. HIST_DEPTH must be a power of two
// so the pointer arithmetic wraps naturally.
module pc_history_ring
    import mips_run_ctrl_pkg::*;
#(
    parameter int HIST_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [31:0]                   wr_pc,
    input  logic [$clog2(HIST_DEPTH)-1:0] rd_idx,
    output logic [31:0]                   rd_pc
);

    localparam int IW = $clog2(HIST_DEPTH);

    logic [31:0]   mem [HIST_DEPTH];
    logic [IW-1:0] wr_ptr;
    logic [IW-1:0] rd_addr;

    // Write the retiring PC at the pointer and advance it; reset clears
    // every entry so unwritten slots read zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < HIST_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
        end else if (wr_en) begin
            mem[wr_ptr] <= wr_pc;
            wr_ptr      <= wr_ptr + IW'(1);
        end
    end

    // Newest entry sits one behind the write pointer; step back rd_idx more.
    always_comb begin
        rd_addr = wr_ptr - IW'(1) - rd_idx;
        rd_pc   = mem[rd_addr];
    end

endmodule

// File: rtl/mips_run_ctrl.sv
// Run controller for the MIPS CPU simulation harness: counted CPU reset
// pulse, run-cycle and retire counters, self-loop halt detection with a
// drain window, and a cycle-budget watchdog. The bench polls done.
//
// Optional feature macro: MIPS_RUN_CTRL_HIST_EN compiles in the retired-PC
// history ring behind hist_idx/hist_pc; without it hist_pc reads zero.
//
// Retire stream: retire_valid has no ready. Every cycle it is high one
// instruction retires and is either counted (RUN, DRAIN) or ignored
// (HOLD, DONE); the core is never back-pressured.
module mips_run_ctrl
    import mips_run_ctrl_pkg::*;
#(
    parameter int RST_CYCLES   = 4,
    parameter int MAX_CYCLES   = 1000,
    parameter int HALT_REPEAT  = 3,
    parameter int DRAIN_CYCLES = 8,
    parameter int HIST_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          retire_valid,
    input  logic [31:0]                   retire_pc,
    output logic                          cpu_reset,
    output logic [31:0]                   cycle_cnt,
    output logic [31:0]                   retire_cnt,
    output logic                          halted,
    output logic                          timeout,
    output logic                          done,
    input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx,
    output logic [31:0]                   hist_pc
);

    localparam int HOLD_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int REP_W   = $clog2(HALT_REPEAT + 1);

    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RST_CYCLES - 1);
    localparam logic [HOLD_W-1:0]  HOLD_ONE   = HOLD_W'(1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);
    localparam logic [REP_W-1:0]   REP_LOAD   = REP_W'(REP_FIRST);
    localparam logic [REP_W-1:0]   REP_INC    = REP_W'(REP_STEP);
    localparam logic [REP_W-1:0]   REP_TARGET = REP_W'(HALT_REPEAT);
    localparam logic [31:0]        MAX_CNT    = 32'(MAX_CYCLES);

    // Registered state (state is kept as a plain vector for probing)
    logic [1:0]         state;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [REP_W-1:0]   rep_cnt;
    logic [31:0]        last_pc;

    // Next-state values
    logic [1:0]         state_n;
    logic [HOLD_W-1:0]  hold_n;
    logic [DRAIN_W-1:0] drain_n;
    logic [REP_W-1:0]   rep_n;
    logic [31:0]        last_pc_n;
    logic               cpu_reset_n;
    logic [31:0]        cycle_n;
    logic [31:0]        retire_n;
    logic               halted_n;
    logic               timeout_n;
    logic               done_n;

    logic [REP_W-1:0]   rep_next;
    logic               halt_hit;
    logic               timeout_hit;

    // Sequencer: decide next state, counters and flags for this edge.
    always_comb begin
        state_n     = state;
        hold_n      = hold_cnt;
        drain_n     = drain_cnt;
        rep_n       = rep_cnt;
        last_pc_n   = last_pc;
        cpu_reset_n = cpu_reset;
        cycle_n     = cycle_cnt;
        retire_n    = retire_cnt;
        halted_n    = halted;
        timeout_n   = timeout;
        done_n      = done;

        // A retire at the previous PC extends the run, anything else restarts it.
        rep_next    = (retire_pc == last_pc) ? (rep_cnt + REP_INC) : REP_LOAD;
        halt_hit    = 1'b0;
        // The budget trips on the edge that would make cycle_cnt reach MAX_CYCLES.
        timeout_hit = (sat_inc(cycle_cnt) == MAX_CNT);

        case (state)
            ST_HOLD: begin
                hold_n = hold_cnt + HOLD_ONE;
                if (hold_cnt == HOLD_LAST) begin
                    state_n     = ST_RUN;
                    cpu_reset_n = 1'b0;
                end
            end

            ST_RUN: begin
                cycle_n = sat_inc(cycle_cnt);
                if (retire_valid) begin
                    retire_n  = sat_inc(retire_cnt);
                    rep_n     = rep_next;
                    last_pc_n = retire_pc;
                    halt_hit  = (rep_next == REP_TARGET);
                end
                // Timeout takes precedence over a halt on the same edge.
                if (timeout_hit) begin
                    state_n   = ST_DONE;
                    timeout_n = 1'b1;
                    done_n    = 1'b1;
                end else if (halt_hit) begin
                    state_n  = ST_DRAIN;
                    halted_n = 1'b1;
                end
            end

            ST_DRAIN: begin
                // Retires still count here, but halt detection is frozen.
                cycle_n = sat_inc(cycle_cnt);
                if (retire_valid) begin
                    retire_n = sat_inc(retire_cnt);
                end
                drain_n = drain_cnt + DRAIN_ONE;
                if (timeout_hit) begin
                    state_n   = ST_DONE;
                    timeout_n = 1'b1;
                    done_n    = 1'b1;
                end else if (drain_cnt == DRAIN_LAST) begin
                    state_n = ST_DONE;
                    done_n  = 1'b1;
                end
            end

            default: begin
                // DONE: everything frozen until the external reset.
            end
        endcase
    end

    // State and output registers; reset drops everything back to HOLD at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_HOLD;
            hold_cnt   <= '0;
            drain_cnt  <= '0;
            rep_cnt    <= '0;
            last_pc    <= '0;
            cpu_reset  <= 1'b1;
            cycle_cnt  <= '0;
            retire_cnt <= '0;
            halted     <= 1'b0;
            timeout    <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            hold_cnt   <= hold_n;
            drain_cnt  <= drain_n;
            rep_cnt    <= rep_n;
            last_pc    <= last_pc_n;
            cpu_reset  <= cpu_reset_n;
            cycle_cnt  <= cycle_n;
            retire_cnt <= retire_n;
            halted     <= halted_n;
            timeout    <= timeout_n;
            done       <= done_n;
        end
    end

`ifdef MIPS_RUN_CTRL_HIST_EN
    logic hist_wr;

    // History records exactly the retires that the retire counter counts.
    assign hist_wr = retire_valid && ((state == ST_RUN) || (state == ST_DRAIN));

    pc_history_ring #(
        .HIST_DEPTH (HIST_DEPTH)
    ) u_pc_history_ring (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (hist_wr),
        .wr_pc  (retire_pc),
        .rd_idx (hist_idx),
        .rd_pc  (hist_pc)
    );
`else
    logic hist_idx_unused;

    // No history storage: read index is ignored and the read port is zero.
    assign hist_idx_unused = ^hist_idx;
    assign hist_pc         = '0;
`endif

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Directed bench for mips_run_ctrl: reset pulse length, halt + drain,
// timeout, halt/timeout collision, async mid-run reset and PC history.
module tb_mips_run_ctrl;
    import mips_run_ctrl_pkg::*;

    localparam int HIST_DEPTH = 8;

    logic        clk;
    logic        reset;
    logic        retire_valid;
    logic [31:0] retire_pc;
    logic        cpu_reset;
    logic [31:0] cycle_cnt;
    logic [31:0] retire_cnt;
    logic        halted;
    logic        timeout;
    logic        done;
    logic [2:0]  hist_idx;
    logic [31:0] hist_pc;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_q[$];

    mips_run_ctrl #(
        .RST_CYCLES   (4),
        .MAX_CYCLES   (100),
        .HALT_REPEAT  (3),
        .DRAIN_CYCLES (8),
        .HIST_DEPTH   (HIST_DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .retire_valid (retire_valid),
        .retire_pc    (retire_pc),
        .cpu_reset    (cpu_reset),
        .cycle_cnt    (cycle_cnt),
        .retire_cnt   (retire_cnt),
        .halted       (halted),
        .timeout      (timeout),
        .done         (done),
        .hist_idx     (hist_idx),
        .hist_pc      (hist_pc)
    );

    // Clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected bench to finish");
        $fatal(1, "watchdog expired");
    end

    // Checking task
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_idle(input int n);
        retire_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic retire(input logic [31:0] pc);
        retire_valid = 1'b1;
        retire_pc    = pc;
        tick();
        retire_valid = 1'b0;
    endtask

    // reset high across two edges, then released; 4 HOLD edges follow
    task automatic do_reset_and_hold();
        reset        = 1'b1;
        retire_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        reset        = 1'b1;
        retire_valid = 1'b0;
        retire_pc    = '0;
        hist_idx     = '0;

        // ---------------- reset and HOLD length ----------------
        #2;
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_cycle_cnt", cycle_cnt, 32'd0);
        check("rst_retire_cnt", retire_cnt, 32'd0);
        check("rst_flags", {29'd0, halted, timeout, done}, 32'd0);
        check("rst_hist_pc", hist_pc, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            tick();
            check($sformatf("hold_edge%0d_cpu_reset", e), 32'(cpu_reset), 32'd1);
            check($sformatf("hold_edge%0d_cycle_cnt", e), cycle_cnt, 32'd0);
        end
        tick();
        check("hold_edge4_cpu_reset", 32'(cpu_reset), 32'd0);
        check("hold_edge4_cycle_cnt", cycle_cnt, 32'd0);

        // ---------------- halt detection + drain ----------------
        retire(32'h3000);
        check("run1_cycle_cnt", cycle_cnt, 32'd1);
        check("run1_retire_cnt", retire_cnt, 32'd1);
        retire(32'h3004);
        retire(32'h3008);
        retire(32'h3008);
        check("halt_4th_halted", 32'(halted), 32'd0);
        check("halt_4th_retire_cnt", retire_cnt, 32'd4);
        retire(32'h3008);
        check("halt_5th_halted", 32'(halted), 32'd1);
        check("halt_5th_retire_cnt", retire_cnt, 32'd5);
        check("halt_5th_cycle_cnt", cycle_cnt, 32'd5);
        check("halt_5th_done", 32'(done), 32'd0);
        retire(32'h3008);
        check("drain_retire_counted", retire_cnt, 32'd6);
        run_idle(6);
        check("drain_7_done", 32'(done), 32'd0);
        run_idle(1);
        check("drain_8_done", 32'(done), 32'd1);
        check("drain_8_timeout", 32'(timeout), 32'd0);
        check("drain_8_halted", 32'(halted), 32'd1);
        check("drain_8_cycle_cnt", cycle_cnt, 32'd13);
        retire(32'h3100);
        retire(32'h3104);
        retire(32'h3108);
        check("done_frozen_retire", retire_cnt, 32'd6);
        check("done_frozen_cycle", cycle_cnt, 32'd13);
        check("done_cpu_reset", 32'(cpu_reset), 32'd0);
        check("done_sticky", {29'd0, halted, timeout, done}, 32'b101);

        // ---------------- timeout, no retires ----------------
        do_reset_and_hold();
        run_idle(99);
        check("to_99_cycle_cnt", cycle_cnt, 32'd99);
        check("to_99_flags", {29'd0, halted, timeout, done}, 32'd0);
        run_idle(1);
        check("to_100_cycle_cnt", cycle_cnt, 32'd100);
        check("to_100_flags", {29'd0, halted, timeout, done}, 32'b011);
        retire(32'h3000);
        retire(32'h3000);
        retire(32'h3000);
        check("to_frozen_cycle", cycle_cnt, 32'd100);
        check("to_frozen_retire", retire_cnt, 32'd0);
        check("to_frozen_flags", {29'd0, halted, timeout, done}, 32'b011);

        // ---------------- halt and timeout on the same edge ----------------
        do_reset_and_hold();
        run_idle(97);
        retire(32'h4000);
        retire(32'h4000);
        check("coll_99_cycle_cnt", cycle_cnt, 32'd99);
        check("coll_99_flags", {29'd0, halted, timeout, done}, 32'd0);
        retire(32'h4000);
        check("coll_100_flags", {29'd0, halted, timeout, done}, 32'b011);
        check("coll_100_retire_cnt", retire_cnt, 32'd3);
        check("coll_100_state", 32'(dut.state), 32'(ST_DONE));
        run_idle(9);
        check("coll_no_late_halt", 32'(halted), 32'd0);

        // ---------------- async reset mid-RUN ----------------
        do_reset_and_hold();
        for (int i = 0; i < 37; i++) begin
            retire(32'h5000 + 32'(4 * i));
        end
        check("mid_37_cycle_cnt", cycle_cnt, 32'd37);
        check("mid_37_retire_cnt", retire_cnt, 32'd37);
        #2;
        reset = 1'b1;
        #1;
        check("async_cpu_reset", 32'(cpu_reset), 32'd1);
        check("async_cycle_cnt", cycle_cnt, 32'd0);
        check("async_retire_cnt", retire_cnt, 32'd0);
        check("async_flags", {29'd0, halted, timeout, done}, 32'd0);
        #1;
        reset        = 1'b0;
        retire_valid = 1'b1;
        retire_pc    = 32'h6000;
        repeat (3) tick();
        check("rehold_3_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rehold_3_retire_ignored", retire_cnt, 32'd0);
        tick();
        check("rehold_4_cpu_reset", 32'(cpu_reset), 32'd0);
        check("rehold_4_cycle_cnt", cycle_cnt, 32'd0);
        tick();
        check("rerun_1_cycle_cnt", cycle_cnt, 32'd1);
        check("rerun_1_retire_cnt", retire_cnt, 32'd1);
        retire_valid = 1'b0;

        // ---------------- PC history ----------------
        do_reset_and_hold();
        hist_idx = 3'd0;
        #1;
        check("hist_empty_idx0", hist_pc, 32'd0);
        for (int i = 0; i < 3; i++) begin
            retire(32'h3000 + 32'(4 * i));
        end
        hist_idx = 3'd0;
        #1;
`ifdef MIPS_RUN_CTRL_HIST_EN
        check("hist_partial_idx0", hist_pc, 32'h3008);
`else
        check("hist_partial_idx0", hist_pc, 32'h0);
`endif
        hist_idx = 3'd3;
        #1;
        check("hist_unwritten_idx3", hist_pc, 32'd0);
        for (int i = 3; i < 10; i++) begin
            retire(32'h3000 + 32'(4 * i));
        end
        check("hist_retire_cnt", retire_cnt, 32'd10);
`ifdef MIPS_RUN_CTRL_HIST_EN
        exp_q = '{32'h3024, 32'h3020, 32'h301C, 32'h3018,
                  32'h3014, 32'h3010, 32'h300C, 32'h3008};
`else
        exp_q = '{32'h0, 32'h0, 32'h0, 32'h0,
                  32'h0, 32'h0, 32'h0, 32'h0};
`endif
        for (int k = 0; k < HIST_DEPTH; k++) begin
            logic [31:0] exp_pc;
            hist_idx = 3'(k);
            #1;
            exp_pc = exp_q.pop_front();
            check($sformatf("hist_idx%0d", k), hist_pc, exp_pc);
        end

        // ---------------- report ----------------
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mips_run_ctrl.md
# mips_run_ctrl

Synthesizable run controller for the MIPS CPU simulation harness. It replaces fixed-delay reset and fixed-time `$finish` with a parametrised sequence:
- a counted CPU reset pulse;
- cycle and retire counters;
- self-loop halt detection, a drain window and a timeout watchdog.

It sits between the bench clock/reset and the CPU's writeback retire stream. The bench polls `done` instead of a hard-coded delay.

## Interface
- RST_CYCLES, 4: rising edges `cpu_reset` stays high after `reset` releases (≥1)
- MAX_CYCLES, 1000: run-cycle budget before timeout (≥1)
- HALT_REPEAT, 3: consecutive retires at the same PC that declare halt (≥2)
- DRAIN_CYCLES, 8: cycles between halt and `done` (≥1)
- HIST_DEPTH, 8: retired-PC history entries (power of two, ≥2)

- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- retire_valid  in  1  one instruction retires this cycle
- retire_pc  in  32  PC of the retiring instruction
- cpu_reset  out  1  reset to the CPU core
- cycle_cnt  out  32  run cycles counted
- retire_cnt  out  32  instructions retired
- halted  out  1  halt detected
- timeout  out  1  cycle budget exhausted
- done  out  1  run finished
- hist_idx  in  $clog2(HIST_DEPTH)  history read index, 0 = most recent
- hist_pc  out  32  PC at `hist_idx`, combinational read

## Operation
- States: HOLD, RUN, DRAIN, DONE.
- Reset values: state HOLD, `cpu_reset`=1, and the following all 0:
  - `cycle_cnt`, `retire_cnt`, `halted`, `timeout`, `done`;
  - the hold, drain and repeat counters;
  - `last_pc`, and history entries and pointer.
- HOLD: `cpu_reset`=1; retires ignored; counters frozen.
  - The hold counter increments each edge.
  - On the RST_CYCLES-th edge after `reset` falls: go to RUN, `cpu_reset`=0.
- RUN and DRAIN:
  - `cycle_cnt` increments each edge; `retire_cnt` increments on each edge with `retire_valid`=1.
  - Both counters saturate at 0xFFFF_FFFF.
- Halt detection (RUN only), on each retire:
  - `retire_pc`==`last_pc`: repeat counter increments.
  - Otherwise the repeat counter loads 1.
  - `last_pc` loads `retire_pc`.
  - When the repeat count reaches HALT_REPEAT: `halted`=1, go to DRAIN.
- DRAIN:
  - Retires are still counted, but halt detection is frozen.
  - After DRAIN_CYCLES edges in DRAIN: go to DONE, `done`=1.
- Timeout (RUN or DRAIN): the edge where `cycle_cnt` becomes MAX_CYCLES sets `timeout`=1 and `done`=1, and goes to DONE.
- Simultaneous halt and timeout on the same edge: timeout wins; `halted` stays 0.
- DONE: terminal.
  - Counters and flags frozen; `cpu_reset`=0; retires ignored.
  - Only `reset` leaves DONE.
- Reset mid-operation, in any state: all outputs return to reset values immediately, without waiting for `clk`. The sequence restarts from HOLD.

## Timing
- All outputs are registered except `hist_pc`.
- `cpu_reset` is high for exactly RST_CYCLES rising edges after `reset` deassertion.
- `cycle_cnt` reads 1 after the first RUN edge.
- `halted` rises on the edge that registers the HALT_REPEAT-th matching retire. `retire_cnt` already includes that retire.
- `done` rises exactly DRAIN_CYCLES edges after `halted`, or on the same edge as `timeout`.
- Once high, `done`, `halted` and `timeout` stay high until `reset`.

## Configuration
- `MIPS_RUN_CTRL_HIST_EN` defined: the PC history is compiled in.
  - A HIST_DEPTH-entry ring buffer is written with `retire_pc` on each counted retire (RUN and DRAIN).
  - The write pointer wraps modulo HIST_DEPTH.
  - `hist_pc` returns the entry `hist_idx` positions before the newest.
  - Entries not yet written read 0.
- Undefined: no history storage; `hist_pc` is tied to 0 and `hist_idx` is ignored. Ports are unchanged.

## Structure
- Package `mips_run_ctrl_pkg` contains:
  - the state enum typedef (HOLD, RUN, DRAIN, DONE);
  - the 32-bit counter saturation constant;
  - the halt-detection rule constants.
- One sub-module: `pc_history_ring`.
  - Parametrised by HIST_DEPTH.
  - Write port: `wr_en`, `wr_pc`. Read port: `rd_idx` → `rd_pc`.
  - Instantiated only under `MIPS_RUN_CTRL_HIST_EN`.

## Test plan
- RST_CYCLES=4, `reset` high 2 cycles then low:
  - `cpu_reset` high through the 4th edge after release and low after it;
  - `cycle_cnt`=0 until RUN.
- HALT_REPEAT=3, DRAIN_CYCLES=8, retires at PCs 0x3000, 0x3004, 0x3008, 0x3008, 0x3008 on consecutive cycles:
  - `halted`=1 with `retire_cnt`=5 on the 5th retire edge;
  - `done`=1 exactly 8 edges later; `timeout`=0.
- MAX_CYCLES=100, no retires: `timeout`=1 and `done`=1 on the edge where `cycle_cnt`=100; `halted`=0; counters then frozen.
- MAX_CYCLES=100, third matching retire lands on edge 100: `timeout`=1, `halted`=0, state DONE.
- `reset` pulsed asynchronously mid-RUN at `cycle_cnt`=37: outputs return to reset values before the next edge; a full HOLD→RUN sequence follows.
- `MIPS_RUN_CTRL_HIST_EN`, HIST_DEPTH=8, retire PCs 0x3000..0x3024 (10 distinct PCs):
  - `hist_idx`=0 → 0x3024; `hist_idx`=7 → 0x3008 (wrap verified).
  - Without the macro, `hist_pc`=0 for all indices.
